// File: rtl/io_pkg.sv
// Shared types and helpers for the UART input buffer.
// Byte type, RX/TX state encoding and bit-period math.
package io_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_st_t;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/if_iobuf.sv
// Byte buffer handshake between the UART front end and its consumer.
// The block side produces bytes; the user side drains them.
interface if_iobuf;
   import io_pkg::*;

   logic  push_back;
   logic  pop_front;
   byte_t data_out;
   logic  empty;
   logic  full;

   modport blk (
      output push_back,
      output data_out,
      output empty,
      output full,
      input  pop_front
   );

   modport usr (
      input  push_back,
      input  data_out,
      input  empty,
      input  full,
      output pop_front
   );

endinterface

// File: rtl/io_fifo.sv
// First-word fall-through byte FIFO with registered empty/full.
// Pointers carry one extra wrap bit to tell full from empty.
module io_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  wr,
   input  byte_t wdata,
   input  logic  rd,
   output byte_t rdata,
   output logic  empty,
   output logic  full
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW:0] ptr_t;

   byte_t mem [DEPTH];
   ptr_t  wp;
   ptr_t  rp;
   ptr_t  wp_n;
   ptr_t  rp_n;
   logic  we;
   logic  re;

   // Qualify strobes and compute next pointers
   always_comb begin
      re   = rd && !empty;
      we   = wr && (!full || re);
      wp_n = we ? wp + ptr_t'(1) : wp;
      rp_n = re ? rp + ptr_t'(1) : rp;
   end

   // Pointer and flag registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         wp    <= wp_n;
         rp    <= rp_n;
         empty <= (wp_n == rp_n);
         full  <= (wp_n[AW] != rp_n[AW]) &&
                  (wp_n[AW-1:0] == rp_n[AW-1:0]);
      end
   end

   // Storage array; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wp[AW-1:0]] <= wdata;
      end
   end

   assign rdata = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/uart_inbuf_io.sv
// 8N1 UART receiver feeding a byte FIFO, with echo on tx.
// RX and TX shifters live here; storage is in io_fifo.
module uart_inbuf_io
   import io_pkg::*;
#(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9_600,
   parameter int DEPTH    = 16
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  rx,
   output logic  tx,
   if_iobuf.blk  inbuf
);

   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CPB_LAST  = cnt_t'(CPB - 1);
   localparam cnt_t HALF_LAST = cnt_t'(HALF - 1);
   localparam cnt_t ONE       = cnt_t'(1);

   logic      rx_m;
   logic      rx_s;
   logic      rx_d;

   uart_st_t  rx_st;
   cnt_t      rx_cnt;
   logic [2:0] rx_bit;
   byte_t     rx_sh;
   logic      rx_vld;

   uart_st_t  tx_st;
   cnt_t      tx_cnt;
   logic [2:0] tx_bit;
   byte_t     tx_sh;
   logic      tx_free;

   logic      push;

   // Synchronizer plus delayed copy; held low in reset so a
   // line that is low at release never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_m <= 1'b0;
         rx_s <= 1'b0;
         rx_d <= 1'b0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   // Receive state machine; rx_vld pulses for a good stop bit
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_st  <= ST_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh  <= '0;
         rx_vld <= 1'b0;
      end else begin
         rx_vld <= 1'b0;
         unique case (rx_st)
            ST_IDLE: begin
               if (rx_d && !rx_s) begin
                  rx_st  <= ST_START;
                  rx_cnt <= '0;
               end
            end
            ST_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_st  <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt <= rx_cnt + ONE;
               end
            end
            ST_DATA: begin
               if (rx_cnt == CPB_LAST) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s, rx_sh[7:1]};
                  rx_bit <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) begin
                     rx_st <= ST_STOP;
                  end
               end else begin
                  rx_cnt <= rx_cnt + ONE;
               end
            end
            ST_STOP: begin
               if (rx_cnt == CPB_LAST) begin
                  rx_cnt <= '0;
                  rx_vld <= rx_s;
                  rx_st  <= ST_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + ONE;
               end
            end
            default: begin
               rx_st <= ST_IDLE;
            end
         endcase
      end
   end

   // A byte is accepted when there is room or room is being made
   assign push = rx_vld && (!inbuf.full || inbuf.pop_front);

   assign inbuf.push_back = push;

   io_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (push),
      .wdata (rx_sh),
      .rd    (inbuf.pop_front),
      .rdata (inbuf.data_out),
      .empty (inbuf.empty),
      .full  (inbuf.full)
   );

   // The final stop-bit cycle counts as free so back-to-back
   // frames chain without a gap
   assign tx_free = (tx_st == ST_IDLE) ||
                    ((tx_st == ST_STOP) && (tx_cnt == CPB_LAST));

   // Echo transmitter; bytes arriving while busy are not echoed
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_st  <= ST_IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
         tx     <= 1'b1;
      end else if (push && tx_free) begin
         tx_st  <= ST_START;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= rx_sh;
         tx     <= 1'b0;
      end else begin
         unique case (tx_st)
            ST_IDLE: begin
               tx <= 1'b1;
            end
            ST_START: begin
               if (tx_cnt == CPB_LAST) begin
                  tx_cnt <= '0;
                  tx_st  <= ST_DATA;
                  tx     <= tx_sh[0];
                  tx_sh  <= {1'b0, tx_sh[7:1]};
               end else begin
                  tx_cnt <= tx_cnt + ONE;
               end
            end
            ST_DATA: begin
               if (tx_cnt == CPB_LAST) begin
                  tx_cnt <= '0;
                  tx_bit <= tx_bit + 3'd1;
                  if (tx_bit == 3'd7) begin
                     tx_st <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     tx    <= tx_sh[0];
                     tx_sh <= {1'b0, tx_sh[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + ONE;
               end
            end
            ST_STOP: begin
               if (tx_cnt == CPB_LAST) begin
                  tx_cnt <= '0;
                  tx_st  <= ST_IDLE;
                  tx     <= 1'b1;
               end else begin
                  tx_cnt <= tx_cnt + ONE;
               end
            end
            default: begin
               tx_st <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_inbuf_io.sv
// Directed and randomized bench for uart_inbuf_io.
// A queue model of the buffer and a line decoder on tx give expectations.
module tb_uart_inbuf_io;
   import io_pkg::*;

   localparam int CF    = 1_600_000;
   localparam int BD    = 100_000;
   localparam int DEPTH = 16;
   localparam int CPB   = CF / BD;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx  = 1'b1;
   logic tx;

   if_iobuf inbuf ();

   uart_inbuf_io #(
      .CLK_FREQ (CF),
      .BAUD     (BD),
      .DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rx    (rx),
      .tx    (tx),
      .inbuf (inbuf)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int push_cnt  = 0;
   int push_dbl  = 0;
   int push_cyc  = 0;
   int frame_cyc = 0;
   int tx_starts = 0;
   int tx_bad    = 0;
   int exp_push  = 0;
   int off       = 0;

   byte_t model[$];
   byte_t echo_exp[$];
   byte_t tx_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // push_back pulse monitor
   initial begin
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (inbuf.push_back === 1'b1) begin
            push_cnt++;
            push_cyc = cyc;
            if (prev) push_dbl++;
         end
         prev = (inbuf.push_back === 1'b1);
      end
   end

   // tx line decoder
   initial begin
      byte_t b;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            tx_starts++;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) tx_bad++;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) tx_bad++;
            tx_q.push_back(b);
         end
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      byte_t head;
      head = (model.size() > 0) ? model[0] : 8'h00;
      check({tag, ".data"}, inbuf.data_out, head);
      check({tag, ".empty"}, inbuf.empty, model.size() == 0);
      check({tag, ".full"}, inbuf.full, model.size() == DEPTH);
   endtask

   task automatic check_echo(input string tag);
      check({tag, ".echo_n"}, tx_q.size(), echo_exp.size());
      for (int i = 0; i < echo_exp.size() && i < tx_q.size(); i++)
         check({tag, ".echo"}, tx_q[i], echo_exp[i]);
      check({tag, ".tx_bad"}, tx_bad, 0);
      tx_q.delete();
      echo_exp.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_frame(input byte_t b, input logic stop);
      frame_cyc = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send(input byte_t b);
      drive_frame(b, 1'b1);
      if (model.size() < DEPTH) begin
         model.push_back(b);
         echo_exp.push_back(b);
         exp_push++;
      end
   endtask

   task automatic pop_one(input string tag);
      @(posedge clk);
      #1 inbuf.pop_front = 1'b1;
      @(posedge clk);
      #1 inbuf.pop_front = 1'b0;
      if (model.size() > 0) void'(model.pop_front());
      check_state(tag);
      @(negedge clk);
   endtask

   initial begin
      int p0;
      int s0;
      int target;
      byte_t b;

      inbuf.pop_front = 1'b0;
      rx  = 1'b1;
      rst = 1'b0;
      idle(4);
      check("rst.empty", inbuf.empty, 1);
      check("rst.full", inbuf.full, 0);
      check("rst.data", inbuf.data_out, 8'h00);
      check("rst.push", inbuf.push_back, 0);
      check("rst.tx", tx, 1);
      rst = 1'b1;
      idle(4);

      // single byte
      p0 = push_cnt;
      send(8'h41);
      off = push_cyc - frame_cyc;
      check("t1.push_cnt", push_cnt - p0, 1);
      check("t1.push_time",
            (off >= 9 * CPB + CPB / 2) && (off <= 9 * CPB + CPB / 2 + 4), 1);
      check_state("t1");
      idle(12 * CPB);
      check_echo("t1");
      pop_one("t1.pop");

      // three bytes then pops, plus extra pops on empty
      p0 = push_cnt;
      send(8'h12);
      send(8'h34);
      send(8'h56);
      check("t2.push_cnt", push_cnt - p0, 3);
      check_state("t2.fill");
      pop_one("t2.pop1");
      pop_one("t2.pop2");
      pop_one("t2.pop3");
      pop_one("t2.pop4");
      pop_one("t2.pop5");
      idle(12 * CPB);
      check_echo("t2");

      // framing error, then a short low glitch
      p0 = push_cnt;
      s0 = tx_starts;
      drive_frame(8'hA5, 1'b0);
      idle(2 * CPB);
      rx = 1'b0;
      idle(CPB / 4);
      rx = 1'b1;
      idle(12 * CPB);
      check("t4.push_cnt", push_cnt - p0, 0);
      check("t4.tx_starts", tx_starts - s0, 0);
      check_state("t4");

      // overfill with no pops
      p0 = push_cnt;
      for (int i = 0; i < DEPTH + 2; i++) begin
         send(byte_t'(i));
         check_state("t3.fill");
      end
      check("t3.push_cnt", push_cnt - p0, DEPTH);
      idle(12 * CPB);
      check_echo("t3");

      // push and pop together on a full buffer
      p0 = push_cnt;
      fork
         drive_frame(8'hC3, 1'b1);
         begin
            #1;
            target = frame_cyc + off;
            do begin
               @(posedge clk);
               #1;
            end while (cyc < target);
            inbuf.pop_front = 1'b1;
            @(posedge clk);
            #1 inbuf.pop_front = 1'b0;
         end
      join
      void'(model.pop_front());
      model.push_back(8'hC3);
      echo_exp.push_back(8'hC3);
      exp_push++;
      check("t5.push_cnt", push_cnt - p0, 1);
      check_state("t5");
      idle(12 * CPB);
      check_echo("t5");
      for (int i = 0; i < DEPTH; i++) pop_one("t5.drain");
      pop_one("t5.extra");

      // reset in the middle of a frame with bytes buffered
      for (int i = 0; i < 3; i++) send(byte_t'($urandom));
      idle(12 * CPB);
      check_echo("t6.pre");
      check_state("t6.pre");
      p0 = push_cnt;
      rx = 1'b0;
      idle(CPB);
      rx = 1'b1;
      idle(2 * CPB);
      rx = 1'b0;
      idle(CPB / 2);
      rst = 1'b0;
      idle(3);
      rx = 1'b1;
      model.delete();
      check("t6.tx", tx, 1);
      check("t6.push", inbuf.push_back, 0);
      check_state("t6.rst");
      rst = 1'b1;
      idle(12 * CPB);
      check("t6.push_cnt", push_cnt - p0, 0);
      b = byte_t'($urandom);
      send(b);
      check_state("t6.post");
      idle(12 * CPB);
      check_echo("t6.post");
      pop_one("t6.pop");

      // random bytes with random draining
      for (int k = 0; k < 8; k++) begin
         send(byte_t'($urandom));
         repeat ($urandom_range(0, 2)) pop_one("rnd.pop");
      end
      idle(12 * CPB);
      check_echo("rnd");
      while (model.size() > 0) pop_one("rnd.drain");

      check("all.push_cnt", push_cnt, exp_push);
      check("all.push_width", push_dbl, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
